// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Loads a DEPTH x 32 instruction RAM from a byte stream and sequences CPU
//   start-up. The pipeline is held while an image is loaded and released
//   afterwards. In RUN, IF fetches are passed to the RAM read port, and
//   addresses beyond DEPTH read as zero (nop).
//
//   Image format: one header byte N (word count, 1..DEPTH), followed by N
//   little-endian 32-bit words.
//
// Ports
//   clk, reset          clock (rising edge), async active-low reset
//   start               one-cycle load request (IDLE/RUN/ERR only)
//   rx_data/valid/ready byte stream handshake
//   pc_addr, instr      IF fetch address and instruction
//   cpu_hold            1 = pipeline frozen
//   mem_raddr/rdata     RAM read port (combinational read)
//   mem_we/waddr/wdata  RAM write port
//   words_loaded        words written by the current or last load
//   load_done           one-cycle pulse at end of a load
//   load_err            sticky error (bad header or timeout)
//
// state  | meaning
// IDLE   | held, waiting for start
// HDR    | waiting for word-count byte
// LOAD   | receiving image bytes
// DONE   | one-cycle completion, last write in flight
// RUN    | CPU released, fetches served from RAM
// ERR    | held after bad header or timeout
module imem_boot_loader #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int TIMEOUT = 100000,
  parameter bit AUTORUN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [30:0]   pc_addr,
  output logic [31:0]   instr,
  output logic          cpu_hold,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   words_loaded,
  output logic          load_done,
  output logic          load_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_DONE, S_RUN, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    hdr_n;
  logic [1:0]    byte_idx;
  logic [23:0]   wbuf;
  logic [AW:0]   word_idx;
  logic [TW-1:0] timer;

  logic hs, start_acc, hdr_bad, last_word, timed_out;
  logic unused_pc;

  assign hs        = rx_valid & rx_ready;
  assign start_acc = start & ((state == S_IDLE) | (state == S_RUN) | (state == S_ERR));
  assign hdr_bad   = (rx_data == 8'd0) || (9'(rx_data) > 9'(DEPTH));
  // word_idx is the index of the word whose last byte is arriving now
  assign last_word = ((9'(word_idx) + 9'd1) == 9'(hdr_n));
  assign timed_out = (timer == TW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (AUTORUN) state <= S_RUN;
      else         state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: if (start) state_nxt = S_HDR;
      S_HDR: begin
        if (hs)             state_nxt = hdr_bad ? S_ERR : S_LOAD;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_LOAD: begin
        if (hs) begin
          if (byte_idx == 2'd3 && last_word) state_nxt = S_DONE;
        end else if (timed_out) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE:  state_nxt = S_RUN;
      default: state_nxt = state;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    cpu_hold  = (state != S_RUN);
    rx_ready  = (state == S_HDR) || (state == S_LOAD);
    load_done = (state == S_DONE);
  end

  // load datapath, timer and write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_n        <= '0;
      byte_idx     <= '0;
      wbuf         <= '0;
      word_idx     <= '0;
      timer        <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      load_err     <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      if (start_acc) begin
        load_err     <= 1'b0;
        words_loaded <= '0;
        timer        <= '0;
        byte_idx     <= '0;
        word_idx     <= '0;
      end

      if (state == S_HDR || state == S_LOAD) begin
        if (hs) timer <= '0;
        else    timer <= timer + 1'b1;
        if (!hs && timed_out) load_err <= 1'b1;
      end

      if (state == S_HDR && hs) begin
        hdr_n    <= rx_data;
        byte_idx <= '0;
        word_idx <= '0;
        if (hdr_bad) load_err <= 1'b1;
      end

      if (state == S_LOAD && hs) begin
        byte_idx <= byte_idx + 1'b1;
        case (byte_idx)
          2'd0: wbuf[7:0]   <= rx_data;
          2'd1: wbuf[15:8]  <= rx_data;
          2'd2: wbuf[23:16] <= rx_data;
          default: begin
            mem_we       <= 1'b1;
            mem_waddr    <= word_idx[AW-1:0];
            mem_wdata    <= {rx_data, wbuf};
            word_idx     <= word_idx + 1'b1;
            words_loaded <= words_loaded + 1'b1;
          end
        endcase
      end
    end
  end

  // fetch path
  assign mem_raddr = pc_addr[AW+1:2];
  assign instr     = (cpu_hold || (pc_addr[30:2] >= 29'(DEPTH))) ? 32'd0 : mem_rdata;
  assign unused_pc = ^pc_addr[1:0];

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [30:0] pc_addr;
  logic [31:0] instr;
  logic        cpu_hold;
  logic [5:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [6:0]  words_loaded;
  logic        load_done;
  logic        load_err;

  imem_boot_loader #(.DEPTH(64), .AW(6), .TIMEOUT(16), .AUTORUN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pc_addr(pc_addr), .instr(instr), .cpu_hold(cpu_hold),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .words_loaded(words_loaded), .load_done(load_done), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with optional pattern fill
  logic [31:0] ram [64];
  logic        ram_init;
  assign mem_rdata = ram[mem_raddr];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
    end
  end

  int we_count = 0;
  int done_count = 0;
  always @(posedge clk) begin
    if (mem_we)    we_count   <= we_count + 1;
    if (load_done) done_count <= done_count + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 40; k++) begin
      if (rx_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte: byte %h not accepted within 40 cycles", b);
    end
  endtask

  typedef struct {
    logic [30:0] pc;
    logic [5:0]  raddr;
    logic [31:0] ins;
  } fvec_t;

  fvec_t       fv [7];
  logic [7:0]  img [8];
  int          we0, d0, n;

  initial begin
    fv[0] = '{31'h0000_0014, 6'd5,  32'hA500_0005};
    fv[1] = '{31'h0000_0100, 6'd0,  32'h0000_0000};
    fv[2] = '{31'h0000_00FC, 6'd63, 32'hA500_003F};
    fv[3] = '{31'h0000_0000, 6'd0,  32'hA500_0000};
    fv[4] = '{31'h0000_0017, 6'd5,  32'hA500_0005};
    fv[5] = '{31'h7FFF_FFFC, 6'd63, 32'h0000_0000};
    fv[6] = '{31'h0000_0104, 6'd1,  32'h0000_0000};
    img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'hEF; img[3] = 8'h21;
    img[4] = 8'h78; img[5] = 8'h56; img[6] = 8'h34; img[7] = 8'h12;

    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    pc_addr = '0; ram_init = 1'b1;
    repeat (2) @(posedge clk);
    #1 ram_init = 1'b0;

    // reset values (AUTORUN=1)
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // fetch path vectors
    for (int i = 0; i < 7; i++) begin
      pc_addr = fv[i].pc;
      #1;
      chk($sformatf("fetch%0d_raddr", i), 32'(mem_raddr), 32'(fv[i].raddr));
      chk($sformatf("fetch%0d_instr", i), instr, fv[i].ins);
      chk($sformatf("fetch%0d_hold", i), 32'(cpu_hold), 32'd0);
    end

    // basic two-word load
    we0 = we_count; d0 = done_count;
    pulse_start();
    chk("hdr_hold", 32'(cpu_hold), 32'd1);
    chk("hdr_ready", 32'(rx_ready), 32'd1);
    pc_addr = 31'h4; #1;
    chk("hold_instr_nop", instr, 32'd0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 8; i++) send_byte(img[i], 0);
    repeat (3) @(posedge clk); #1;
    chk("load1_ram0", ram[0], 32'h21EF_0001);
    chk("load1_ram1", ram[1], 32'h1234_5678);
    chk("load1_we_cnt", 32'(we_count - we0), 32'd2);
    chk("load1_done_cnt", 32'(done_count - d0), 32'd1);
    chk("load1_words", 32'(words_loaded), 32'd2);
    chk("load1_hold", 32'(cpu_hold), 32'd0);
    chk("load1_err", 32'(load_err), 32'd0);
    pc_addr = 31'h4; #1;
    chk("load1_fetch1", instr, 32'h1234_5678);
    pc_addr = 31'h0; #1;
    chk("load1_fetch0", instr, 32'h21EF_0001);

    // bad headers
    we0 = we_count;
    pulse_start();
    chk("hdr0_words_clr", 32'(words_loaded), 32'd0);
    send_byte(8'h00, 0);
    chk("hdr0_err", 32'(load_err), 32'd1);
    chk("hdr0_hold", 32'(cpu_hold), 32'd1);
    chk("hdr0_ready", 32'(rx_ready), 32'd0);
    pulse_start();
    chk("err_start_clr", 32'(load_err), 32'd0);
    chk("err_start_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h41, 0);
    chk("hdr41_err", 32'(load_err), 32'd1);
    chk("hdr41_hold", 32'(cpu_hold), 32'd1);
    chk("hdr_bad_no_we", 32'(we_count - we0), 32'd0);

    // header == DEPTH is accepted; abandon it via timeout
    pulse_start();
    send_byte(8'h40, 0);
    chk("hdr40_err", 32'(load_err), 32'd0);
    chk("hdr40_ready", 32'(rx_ready), 32'd1);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (load_err) begin n = k; break; end
    end
    chk("hdr40_timeout", 32'(n), 32'd16);

    // load with rx_valid toggling, start pulse in LOAD ignored
    ram_init = 1'b1;
    @(posedge clk); #1;
    ram_init = 1'b0;
    we0 = we_count; d0 = done_count;
    pulse_start();
    send_byte(8'h02, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) pulse_start();
      send_byte(img[i], 1);
    end
    repeat (3) @(posedge clk); #1;
    chk("tog_ram0", ram[0], 32'h21EF_0001);
    chk("tog_ram1", ram[1], 32'h1234_5678);
    chk("tog_ram2", ram[2], 32'hA500_0002);
    chk("tog_we_cnt", 32'(we_count - we0), 32'd2);
    chk("tog_done_cnt", 32'(done_count - d0), 32'd1);
    chk("tog_words", 32'(words_loaded), 32'd2);
    chk("tog_hold", 32'(cpu_hold), 32'd0);

    // timeout on a partial word
    we0 = we_count;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (load_err) begin n = k; break; end
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_hold", 32'(cpu_hold), 32'd1);
    chk("to_no_we", 32'(we_count - we0), 32'd0);
    chk("to_ram0_kept", ram[0], 32'h21EF_0001);
    d0 = done_count;
    pulse_start();
    chk("to_recover_err", 32'(load_err), 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    repeat (3) @(posedge clk); #1;
    chk("rec_ram0", ram[0], 32'hDDCC_BBAA);
    chk("rec_words", 32'(words_loaded), 32'd1);
    chk("rec_done_cnt", 32'(done_count - d0), 32'd1);
    chk("rec_hold", 32'(cpu_hold), 32'd0);

    // reset during LOAD
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    #2 reset = 1'b0;
    #1;
    chk("mrst_hold", 32'(cpu_hold), 32'd0);
    chk("mrst_ready", 32'(rx_ready), 32'd0);
    chk("mrst_we", 32'(mem_we), 32'd0);
    chk("mrst_words", 32'(words_loaded), 32'd0);
    chk("mrst_done", 32'(load_done), 32'd0);
    chk("mrst_err", 32'(load_err), 32'd0);
    chk("mrst_waddr", 32'(mem_waddr), 32'd0);
    chk("mrst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ram0", ram[0], 32'h7766_5544);
    chk("mrst_ram1_kept", ram[1], 32'h1234_5678);

    // start with a byte in RUN: byte must not be taken as header
    rx_valid = 1'b1; rx_data = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0;
    chk("runbyte_ready", 32'(rx_ready), 32'd1);
    chk("runbyte_err", 32'(load_err), 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h0D, 0);
    send_byte(8'hF0, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    repeat (3) @(posedge clk); #1;
    chk("runbyte_ram0", ram[0], 32'hDEAD_F00D);
    chk("runbyte_words", 32'(words_loaded), 32'd1);
    chk("runbyte_hold", 32'(cpu_hold), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
